// File: rtl/serial_sub4_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Handshake: start is a request sampled only while idle (busy=0); done pulses for one
// cycle when d/bo/v carry the new result, and those outputs then hold until the next done.
interface serial_sub4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             v;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    modport master (
        output start, a, b, bi,
        input  d, bo, v, busy, done, dbg_state
    );

    modport slave (
        input  start, a, b, bi,
        output d, bo, v, busy, done, dbg_state
    );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: d = a - b - bi, one bit per cycle LSB-first through a single
// borrow flip-flop, with a start/done handshake.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    serial_sub4_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic x, y, diff_bit, br_next;

    assign x        = a_sr[0];
    assign y        = b_sr[0];
    assign diff_bit = x ^ y ^ br;
    assign br_next  = (~x & y) | (~(x ^ y) & br);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            bus.d  <= '0;
            bus.bo <= 1'b0;
            bus.v  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        br    <= bus.bi;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= {diff_bit, res[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    // MSB stage: overflow is borrow-in XOR borrow-out of this bit.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bus.v  <= br ^ br_next;
                        bus.d  <= {diff_bit, res[WIDTH-1:1]};
                        bus.bo <= br_next;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_serial_sub4.sv
// Randomized and directed checks of serial_sub4 against an arithmetic reference model.
module tb_serial_sub4;
  localparam int W = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [W+1:0] exp_q[$];

  serial_sub4_if #(.WIDTH(W)) bus_if ();

  serial_sub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {bo, v, d}.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bi);
    int u, sa, sb, s;
    logic [W-1:0] dd;
    logic bo, ov;
    u  = int'(a) - int'(b) - int'(bi);
    sa = (int'(a) >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
    sb = (int'(b) >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
    s  = sa - sb - int'(bi);
    dd = W'(u & ((1 << W) - 1));
    bo = (u < 0);
    ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    return {bo, ov, dd};
  endfunction

  // driver: one operation, returns at the negedge inside the DONE cycle
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input bit poke);
    int lat;
    bit got;
    logic [W+1:0] e;
    exp_q.push_back(ref_sub(a, b, bi));
    @(negedge clk);
    check("idle_busy", 32'(bus_if.busy), 32'd0);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.bi    = bi;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.a     = W'($urandom);
    bus_if.b     = W'($urandom);
    bus_if.bi    = 1'($urandom);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      bus_if.start = poke && (lat == 2);
      if (bus_if.done) got = 1;
    end
    bus_if.start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(W + 1));
    if (got) begin
      e = exp_q.pop_front();
      check("d", 32'(bus_if.d), 32'(e[W-1:0]));
      check("bo", 32'(bus_if.bo), 32'(e[W+1]));
      check("v", 32'(bus_if.v), 32'(e[W]));
      check("busy_at_done", 32'(bus_if.busy), 32'd1);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int idx[512];
    int tmp, j;
    bit saw_done;
    logic [W+1:0] last;

    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.bi    = 1'b0;
    #1;
    check("rst_d", 32'(bus_if.d), 32'd0);
    check("rst_bo", 32'(bus_if.bo), 32'd0);
    check("rst_v", 32'(bus_if.v), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // directed cases from the plan
    do_op(4'd7, 4'd3, 1'b0, 0);
    do_op(4'd3, 4'd7, 1'b0, 0);
    do_op(4'd8, 4'd1, 1'b0, 0);
    do_op(4'd0, 4'd8, 1'b0, 0);
    do_op(4'd0, 4'd0, 1'b1, 0);
    do_op(4'd8, 4'd0, 1'b1, 0);
    // start re-asserted mid-CALC must be ignored
    do_op(4'd3, 4'd7, 1'b0, 1);

    // outputs hold while idle
    last = ref_sub(4'd3, 4'd7, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_d", 32'(bus_if.d), 32'(last[W-1:0]));
    check("hold_bo", 32'(bus_if.bo), 32'(last[W+1]));

    // reset mid-CALC after two bit-cycles
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 4'd9;
    bus_if.b     = 4'd4;
    bus_if.bi    = 1'b0;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_d", 32'(bus_if.d), 32'd0);
    check("abort_bo", 32'(bus_if.bo), 32'd0);
    check("abort_v", 32'(bus_if.v), 32'd0);
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (bus_if.done) saw_done = 1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    do_op(4'd5, 4'd2, 1'b0, 0);

    // every (a, b, bi) combination in shuffled order, back-to-back
    for (int i = 0; i < 512; i++) idx[i] = i;
    for (int i = 511; i > 0; i--) begin
      j      = int'($urandom_range(i, 0));
      tmp    = idx[i];
      idx[i] = idx[j];
      idx[j] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      do_op(W'(idx[i] & 15), W'((idx[i] >> 4) & 15), 1'((idx[i] >> 8) & 1), ($urandom_range(3, 0) == 0));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
